// File: rtl/b10_downcounter_pkg.sv
// Shared constants and types for the BCD down-counter and its digit subtractor.
package b10_downcounter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  // Clamp a loaded digit to legal BCD so the count never holds 0xA..0xF.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
    return (d > BCD_NINE) ? BCD_NINE : d;
  endfunction

endpackage

// File: rtl/b10_halfsub.sv
// One-digit combinational BCD half subtractor (d = x - bin, 0 borrows to 9).
// GATE_LEVEL selects the explicit gate netlist form; output is don't-care for x > 9.
module b10_halfsub
  import b10_downcounter_pkg::*;
#(
  parameter bit GATE_LEVEL = 1'b0
) (
  input  logic [BCD_W-1:0] x3_x0,
  input  logic             bin,
  output logic [BCD_W-1:0] d3_d0,
  output logic             bout
);

  generate
    if (GATE_LEVEL) begin : g_gate
      logic x_zero;
      logic lo2_zero;
      logic lo1_zero;
      logic [BCD_W-1:0] dec;

      assign lo1_zero = ~x3_x0[0];
      assign lo2_zero = ~x3_x0[1] & ~x3_x0[0];
      assign x_zero   = ~x3_x0[3] & ~x3_x0[2] & lo2_zero;

      // Plain binary decrement, with bits 1 and 2 forced low so 0 lands on 1001.
      assign dec[0] = ~x3_x0[0];
      assign dec[1] = ~(x3_x0[1] ^ x3_x0[0]) & ~x_zero;
      assign dec[2] = (x3_x0[2] ^ lo2_zero) & ~x_zero;
      assign dec[3] = x3_x0[3] ^ (~x3_x0[2] & lo2_zero);

      assign d3_d0[0] = (bin & dec[0]) | (~bin & x3_x0[0]);
      assign d3_d0[1] = (bin & dec[1]) | (~bin & x3_x0[1]);
      assign d3_d0[2] = (bin & dec[2]) | (~bin & x3_x0[2]);
      assign d3_d0[3] = (bin & dec[3]) | (~bin & x3_x0[3]);
      assign bout     = bin & x_zero & lo1_zero;
    end else begin : g_rtl
      logic x_zero;

      assign x_zero = (x3_x0 == '0);
      assign bout   = bin & x_zero;

      always_comb begin
        d3_d0 = x3_x0;
        if (bin) begin
          d3_d0 = x_zero ? BCD_NINE : (x3_x0 - 4'd1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/b10_downcounter.sv
// Multi-digit BCD down-counter with load, enable and expiry pulse.
// Build option B10_DOWNCOUNTER_WRAP_EN: wrap 0 -> all nines and keep running instead of saturating.
module b10_downcounter
  import b10_downcounter_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter bit GATE_LEVEL = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset_,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] din,
  input  logic                    en,
  output logic [BCD_W*DIGITS-1:0] q,
  output logic                    zero,
  output logic                    done,
  output logic                    busy
);

  localparam int W = BCD_W * DIGITS;

  state_t          state;
  logic [W-1:0]    load_val;
  logic [W-1:0]    dec_q;
  logic [DIGITS:0] borrow;
  logic            load_zero;
  logic            dec_zero;
  logic            underflow;

  always_comb begin
    load_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_val[i*BCD_W +: BCD_W] = bcd_sat(din[i*BCD_W +: BCD_W]);
    end
  end

  // Borrow ripples through per-digit zero detects only, so the chain stays shallow at 8 digits.
  assign borrow[0] = en;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      b10_halfsub #(
        .GATE_LEVEL(GATE_LEVEL)
      ) u_halfsub (
        .x3_x0 (q[i*BCD_W +: BCD_W]),
        .bin   (borrow[i]),
        .d3_d0 (dec_q[i*BCD_W +: BCD_W]),
        .bout  (borrow[i+1])
      );
    end
  endgenerate

  assign underflow = borrow[DIGITS];
  assign load_zero = (load_val == '0);
  assign dec_zero  = (dec_q == '0);
  assign zero      = (q == '0);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= S_IDLE;
      q     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        q <= load_val;
        if (load_zero) begin
          state <= S_EXPIRED;
          busy  <= 1'b0;
        end else begin
          state <= S_RUN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          S_RUN: begin
            if (en) begin
`ifdef B10_DOWNCOUNTER_WRAP_EN
              q <= dec_q;
              if (dec_zero) begin
                done <= 1'b1;
              end
`else
              // RUN never holds zero here; the guard keeps a stray underflow from wrapping.
              q <= underflow ? '0 : dec_q;
              if (dec_zero || underflow) begin
                done  <= ~underflow;
                state <= S_EXPIRED;
                busy  <= 1'b0;
              end
`endif
            end
          end
          S_EXPIRED: begin
            q <= '0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_b10_downcounter.sv
// Scoreboard bench for b10_downcounter: directed steps queue expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_b10_downcounter;

  logic        clock;
  logic        reset_;
  logic        load;
  logic [15:0] din;
  logic        en;
  logic [15:0] q;
  logic        zero;
  logic        done;
  logic        busy;

  typedef struct {
    int          at;
    logic [15:0] q;
    logic        done;
    logic        busy;
    logic        zero;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   ncyc   = 0;
  int   checks = 0;
  int   errors = 0;

  b10_downcounter #(.DIGITS(4)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .load   (load),
    .din    (din),
    .en     (en),
    .q      (q),
    .zero   (zero),
    .done   (done),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, limit 200000 ns");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (negedge %0d)", name, act, req, ncyc);
    end
  endtask

  // Monitor: compare every expectation scheduled for this negedge.
  always @(negedge clock) begin
    ncyc++;
    while (exp_q.size() > 0 && exp_q[0].at <= ncyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.at < ncyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation missed, due %0d now %0d", e.name, e.at, ncyc);
      end else begin
        check({e.name, ".q"},    q,            e.q);
        check({e.name, ".done"}, {15'd0, done}, {15'd0, e.done});
        check({e.name, ".busy"}, {15'd0, busy}, {15'd0, e.busy});
        check({e.name, ".zero"}, {15'd0, zero}, {15'd0, e.zero});
      end
    end
  end

  task automatic expect_next(input string name, input logic [15:0] eq,
                             input logic ed, input logic eb, input logic ez);
    exp_t e;
    e.at = ncyc + 1;
    e.q = eq;
    e.done = ed;
    e.busy = eb;
    e.zero = ez;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs and record what the next negedge must show.
  task automatic step(input string name, input logic ld, input logic [15:0] d, input logic e,
                      input logic [15:0] eq, input logic ed, input logic eb, input logic ez);
    load = ld;
    din  = d;
    en   = e;
    expect_next(name, eq, ed, eb, ez);
    @(negedge clock);
    #1;
  endtask

  logic [15:0] cd_vals [12];

  initial begin
    cd_vals = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    reset_ = 1'b0;
    load   = 1'b0;
    din    = '0;
    en     = 1'b0;
    @(negedge clock);
    #1;

    step("rst0", 1'b1, 16'h0123, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    step("rst1", 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    reset_ = 1'b1;
    step("idle", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

    step("load12", 1'b1, 16'h0012, 1'b1, 16'h0012, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step("count", 1'b0, 16'h0000, 1'b1, cd_vals[i], 1'b0, 1'b1, 1'b0);
    end
    step("expire", 1'b0, 16'h0000, 1'b1, cd_vals[11], 1'b1, 1'b0, 1'b1);
    step("exp_hold", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

    step("ld1000", 1'b1, 16'h1000, 1'b0, 16'h1000, 1'b0, 1'b1, 1'b0);
    step("ripple", 1'b0, 16'h0000, 1'b1, 16'h0999, 1'b0, 1'b1, 1'b0);
    step("ripple2", 1'b0, 16'h0000, 1'b1, 16'h0998, 1'b0, 1'b1, 1'b0);
    step("hold", 1'b0, 16'h0000, 1'b0, 16'h0998, 1'b0, 1'b1, 1'b0);

    step("ld0001", 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0);
    step("prio", 1'b1, 16'h0050, 1'b1, 16'h0050, 1'b0, 1'b1, 1'b0);
    step("prio_hold", 1'b0, 16'h0000, 1'b0, 16'h0050, 1'b0, 1'b1, 1'b0);

    step("sanit", 1'b1, 16'h0A0F, 1'b0, 16'h0909, 1'b0, 1'b1, 1'b0);
    step("sanitF", 1'b1, 16'hFFFF, 1'b0, 16'h9999, 1'b0, 1'b1, 1'b0);
    step("ld_zero", 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

    step("ld_one", 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0);
`ifdef B10_DOWNCOUNTER_WRAP_EN
    step("wrap_done", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
    step("wrap9999", 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0);
    step("wrap9998", 1'b0, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b1, 1'b0);
`else
    step("one_done", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    step("sat_hold", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
`endif

    step("ld0043", 1'b1, 16'h0043, 1'b0, 16'h0043, 1'b0, 1'b1, 1'b0);
    step("at0042", 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b0, 1'b1, 1'b0);
    // Reset asserted between a posedge and the following negedge.
    expect_next("midrst", 16'h0000, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    reset_ = 1'b0;
    @(negedge clock);
    #1;
    step("midrst_hold", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    reset_ = 1'b1;
    step("post_rst", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

    load = 1'b0;
    en   = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
